// File: rtl/uproc_control_fsm.sv
// -----------------------------------------------------------------------------
// uproc_control_fsm
//   Multicycle control unit for the uprocesador datapath. Sequences
//   IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives every datapath
//   control strobe. Only the state and the sticky illegal flag are registered;
//   all control outputs are decoded from the current state plus the
//   instruction fields read back from the datapath.
//
//   Parameters
//     STATE_W          state register width (7 states used, needs 3)
//     HALT_ON_ILLEGAL  1: illegal instruction parks the FSM in HALT
//                      0: flag it, treat it as a NOP and refetch
//
//   Optional feature (macro UPROC_MEM_WAIT_EN)
//     defined  : i_ram_rdy port exists; MEM holds until i_ram_rdy=1
//     undefined: no i_ram_rdy port; MEM lasts exactly one cycle
//
//   Ports
//     clk, rst            clock (rising edge), async active-low reset
//     i_run               run request, sampled in IDLE and at instruction end
//     opc/func3/func7     instruction fields from the datapath IR
//     o_zero              ALU zero flag (valid in EXEC)
//     i_ram_rdy           RAM access complete (UPROC_MEM_WAIT_EN only)
//     o_im_type           immediate format I=0 S=1 B=2 U=3
//     o_we_I              IR load
//     o_C_pc              PC control HOLD/INC/JUMP/CLR
//     o_op_ALU            ALU operation
//     o_we_reg, o_w_AR    regfile write, RAM address register load
//     o_sel_datos_*       ALU A/B and regfile write-data muxes
//     o_we_RAM            RAM write strobe
//     o_illegal           sticky illegal-instruction flag
//     o_state             current state (debug)
// -----------------------------------------------------------------------------
module uproc_control_fsm #(
   parameter int STATE_W         = 3,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_run,
   input  logic [6:0]         opc,
   input  logic [2:0]         func3,
   input  logic [6:0]         func7,
   input  logic               o_zero,
`ifdef UPROC_MEM_WAIT_EN
   input  logic               i_ram_rdy,
`endif
   output logic [2:0]         o_im_type,
   output logic               o_we_I,
   output logic [1:0]         o_C_pc,
   output logic [2:0]         o_op_ALU,
   output logic               o_we_reg,
   output logic               o_w_AR,
   output logic               o_sel_datos_rs1,
   output logic               o_sel_datos_rs2,
   output logic               o_sel_datos_int,
   output logic               o_we_RAM,
   output logic               o_illegal,
   output logic [STATE_W-1:0] o_state
);

   typedef enum logic [STATE_W-1:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_LD   = 7'b0000011;
   localparam logic [6:0] OPC_ST   = 7'b0100011;
   localparam logic [6:0] OPC_BR   = 7'b1100011;
   localparam logic [6:0] OPC_LUI  = 7'b0110111;
   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_XOR   = 3'd4;
   localparam logic [2:0] ALU_SLL   = 3'd5;
   localparam logic [2:0] ALU_SRL   = 3'd6;
   localparam logic [2:0] ALU_PASSB = 3'd7;

   localparam logic [2:0] IM_I = 3'd0;
   localparam logic [2:0] IM_S = 3'd1;
   localparam logic [2:0] IM_B = 3'd2;
   localparam logic [2:0] IM_U = 3'd3;

   localparam logic [1:0] PC_HOLD = 2'd0;
   localparam logic [1:0] PC_INC  = 2'd1;
   localparam logic [1:0] PC_JUMP = 2'd2;
   localparam logic [1:0] PC_CLR  = 2'd3;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;

   // ---------------------------------------------------------------------------
   // Instruction decode. The IR is stable from DECODE until the next FETCH,
   // so the same decode serves EXEC, MEM and WB (WB holds the EXEC controls).
   // ---------------------------------------------------------------------------
   logic [2:0] f3_op, ex_op, ex_im;
   logic       ex_rs2, illegal_dec;
   logic       is_ld, is_st, is_br, br_take;

   always_comb begin
      f3_op = ALU_ADD;
      case (func3)
         3'b000:  f3_op = ALU_ADD;
         3'b111:  f3_op = ALU_AND;
         3'b110:  f3_op = ALU_OR;
         3'b100:  f3_op = ALU_XOR;
         3'b001:  f3_op = ALU_SLL;
         3'b101:  f3_op = ALU_SRL;
         default: f3_op = ALU_ADD;
      endcase
   end

   assign is_ld   = (opc == OPC_LD);
   assign is_st   = (opc == OPC_ST);
   assign is_br   = (opc == OPC_BR);
   assign br_take = ((func3 == 3'b000) &&  o_zero) ||
                    ((func3 == 3'b001) && !o_zero);

   always_comb begin
      ex_op       = ALU_ADD;
      ex_im       = IM_I;
      ex_rs2      = 1'b0;
      illegal_dec = 1'b0;
      case (opc)
         OPC_R: begin
            ex_op = (func7 == F7_ALT) ? ALU_SUB : f3_op;
            if ((func7 != F7_BASE) && (func7 != F7_ALT))
               illegal_dec = 1'b1;
            // the alternate funct7 only encodes SUB
            if ((func7 == F7_ALT) && (func3 != 3'b000))
               illegal_dec = 1'b1;
         end
         OPC_I: begin
            // no SUBI: funct7 is ignored, funct3=000 is always ADD
            ex_op  = f3_op;
            ex_rs2 = 1'b1;
         end
         OPC_LD: begin
            ex_rs2 = 1'b1;
         end
         OPC_ST: begin
            ex_im  = IM_S;
            ex_rs2 = 1'b1;
         end
         OPC_BR: begin
            ex_im = IM_B;
            ex_op = ALU_SUB;
            if (func3[2:1] != 2'b00)
               illegal_dec = 1'b1;
         end
         OPC_LUI: begin
            ex_im  = IM_U;
            ex_rs2 = 1'b1;
            ex_op  = ALU_PASSB;
         end
         default: illegal_dec = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   state_t end_state;
   assign end_state = i_run ? S_FETCH : S_IDLE;

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE:   if (i_run) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (illegal_dec) begin
               illegal_d = 1'b1;
               state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_ld || is_st) state_d = S_MEM;
            else if (is_br)     state_d = end_state;
            else                state_d = S_WB;
         end
         S_MEM: begin
`ifdef UPROC_MEM_WAIT_EN
            if (i_ram_rdy)
               state_d = is_ld ? S_WB : end_state;
`else
            state_d = is_ld ? S_WB : end_state;
`endif
         end
         S_WB:     state_d = end_state;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Control outputs. Gated by rst so every strobe drops in the same cycle
   // reset is asserted, even before the state register is observed.
   // ---------------------------------------------------------------------------
   always_comb begin
      o_im_type       = IM_I;
      o_we_I          = 1'b0;
      o_C_pc          = PC_HOLD;
      o_op_ALU        = ALU_ADD;
      o_we_reg        = 1'b0;
      o_w_AR          = 1'b0;
      o_sel_datos_rs1 = 1'b0;
      o_sel_datos_rs2 = 1'b0;
      o_sel_datos_int = 1'b0;
      o_we_RAM        = 1'b0;
      if (rst) begin
         case (state_q)
            S_IDLE:  if (!i_run) o_C_pc = PC_CLR;
            S_FETCH: begin
               o_we_I = 1'b1;
               o_C_pc = PC_INC;
            end
            S_EXEC: begin
               o_im_type       = ex_im;
               o_op_ALU        = ex_op;
               o_sel_datos_rs2 = ex_rs2;
               o_w_AR          = is_ld || is_st;
               if (is_br && br_take) o_C_pc = PC_JUMP;
            end
            // address register already loaded; only the store strobe matters
            S_MEM:   o_we_RAM = is_st;
            S_WB: begin
               o_im_type       = ex_im;
               o_op_ALU        = ex_op;
               o_sel_datos_rs2 = ex_rs2;
               o_we_reg        = 1'b1;
               o_sel_datos_int = is_ld;
            end
            default: ;
         endcase
      end
   end

   assign o_illegal = illegal_q;
   assign o_state   = state_q;

endmodule
